camera_eth_line_reader: RTL and testbench

//  Read side of the camera line FIFO. The write side fills the FIFO with per-line records:
//  2-byte line number (little-endian), then the line's pixel bytes.

---
 rtl/camera_eth_line_reader.sv | 196 +++++++++++++++++++
 tb/tb_camera_eth_line_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_eth_line_reader.sv
// Read side of the camera line FIFO: waits for one complete line record, then
// streams it to the UDP TX engine byte-by-byte and checks line-number continuity.
module camera_eth_line_reader #(
    parameter int unsigned PKT_BYTES  = 1282,
    parameter int unsigned FIFO_AW    = 12,
    parameter int unsigned IFG_CYCLES = 16
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               fifo_aclr,
    input  logic [FIFO_AW-1:0] rdusedw,
    output logic               rdreq,
    input  logic [7:0]         rddata,
    output logic               Tx_Start,
    output logic [15:0]        Tx_Byte_Num,
    input  logic               Tx_Req,
    output logic [7:0]         Tx_Data,
    input  logic               Tx_Done,
    output logic [15:0]        Line_Num,
    output logic               Seq_Err,
    output logic               Abort
);

    localparam logic [15:0] LP_PKT      = 16'(PKT_BYTES);
    localparam logic [15:0] LP_PKT_LAST = 16'(PKT_BYTES - 1);
    localparam logic [15:0] LP_IFG_LAST = 16'(IFG_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SEND,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;

    logic        r_aclr_m;
    logic        r_aclr_s;
    logic        r_aclr_d;
    logic        w_aclr_rise;

    logic [15:0] r_cnt;
    logic [15:0] r_gap;
    logic [15:0] r_byte_num;
    logic        r_aborted;

    logic        r_pop_d;
    logic        r_pop_b0;
    logic        r_pop_b1;
    logic [7:0]  r_line_lo;
    logic [15:0] r_line;
    logic        r_seq_err;

    logic        w_level_ok;
    logic        w_accept;
    logic        w_hdr_done;
    logic [15:0] w_new_line;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_aclr_m <= 1'b0;
            r_aclr_s <= 1'b0;
            r_aclr_d <= 1'b0;
        end else begin
            r_aclr_m <= fifo_aclr;
            r_aclr_s <= r_aclr_m;
            r_aclr_d <= r_aclr_s;
        end
    end

    assign w_aclr_rise = r_aclr_s & ~r_aclr_d;
    assign w_level_ok  = (32'(rdusedw) >= PKT_BYTES);

    // Requests past the record length are still answered (with zeros) but never pop the FIFO.
    assign w_accept = (r_state == S_SEND) && Tx_Req && (r_cnt < LP_PKT);

    always_comb begin
        rdreq = w_accept && !r_aclr_s && !r_aborted;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (!r_aclr_s && w_level_ok) begin
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                w_state_nx = S_SEND;
            end
            S_SEND: begin
                if (w_accept && (r_cnt == LP_PKT_LAST)) begin
                    w_state_nx = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (Tx_Done) begin
                    w_state_nx = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap == LP_IFG_LAST) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt      <= '0;
            r_gap      <= '0;
            r_byte_num <= '0;
            r_aborted  <= 1'b0;
        end else begin
            if (r_state == S_START) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + 16'd1;
            end

            if (r_state == S_GAP) begin
                r_gap <= r_gap + 16'd1;
            end else begin
                r_gap <= '0;
            end

            // Length must already be valid while Tx_Start is high.
            if ((r_state == S_IDLE) && (w_state_nx == S_START)) begin
                r_byte_num <= LP_PKT;
            end

            if (r_state == S_START) begin
                r_aborted <= 1'b0;
            end else if ((r_state == S_SEND) && r_aclr_s) begin
                r_aborted <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_pop_d  <= 1'b0;
            r_pop_b0 <= 1'b0;
            r_pop_b1 <= 1'b0;
        end else begin
            r_pop_d  <= rdreq;
            r_pop_b0 <= rdreq && (r_cnt == 16'd0);
            r_pop_b1 <= rdreq && (r_cnt == 16'd1);
        end
    end

    assign w_new_line = {rddata, r_line_lo};
    assign w_hdr_done = r_pop_d && r_pop_b1;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_line_lo <= '0;
            r_line    <= '0;
            r_seq_err <= 1'b0;
        end else begin
            if (r_pop_d && r_pop_b0) begin
                r_line_lo <= rddata;
            end

            // Line 0 marks a new frame, so it never counts as a discontinuity.
            r_seq_err <= w_hdr_done && (w_new_line != 16'd0) &&
                         (w_new_line != (r_line + 16'd1));
            if (w_hdr_done) begin
                r_line <= w_new_line;
            end
        end
    end

    assign Tx_Start    = (r_state == S_START);
    assign Tx_Byte_Num = r_byte_num;
    assign Tx_Data     = r_pop_d ? rddata : '0;
    assign Line_Num    = r_line;
    assign Seq_Err     = r_seq_err;
    assign Abort       = (r_state == S_SEND) && w_aclr_rise;

endmodule

// File: tb/tb_camera_eth_line_reader.sv
// Scoreboard bench for camera_eth_line_reader: a queue-based FIFO model feeds the
// DUT, stimulus pushes expected payload bytes, a monitor pops and compares them.
module tb_camera_eth_line_reader;

    localparam int PKT = 1282;
    localparam int IFG = 16;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        fifo_aclr = 1'b0;
    logic [11:0] rdusedw = '0;
    logic        rdreq;
    logic [7:0]  rddata = '0;
    logic        Tx_Start;
    logic [15:0] Tx_Byte_Num;
    logic        Tx_Req = 1'b0;
    logic [7:0]  Tx_Data;
    logic        Tx_Done = 1'b0;
    logic [15:0] Line_Num;
    logic        Seq_Err;
    logic        Abort;

    camera_eth_line_reader #(
        .PKT_BYTES (1282),
        .FIFO_AW   (12),
        .IFG_CYCLES(16)
    ) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .fifo_aclr  (fifo_aclr),
        .rdusedw    (rdusedw),
        .rdreq      (rdreq),
        .rddata     (rddata),
        .Tx_Start   (Tx_Start),
        .Tx_Byte_Num(Tx_Byte_Num),
        .Tx_Req     (Tx_Req),
        .Tx_Data    (Tx_Data),
        .Tx_Done    (Tx_Done),
        .Line_Num   (Line_Num),
        .Seq_Err    (Seq_Err),
        .Abort      (Abort)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cyc = 0;
    int rdreq_cnt = 0;
    int seq_cnt = 0;
    int abort_cnt = 0;
    int start_cnt = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] rec[PKT];

    function automatic void check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endfunction

    always @(posedge Clk) cyc <= cyc + 1;

    // FIFO read port model: rdreq sampled mid-cycle, data presented just after the edge.
    initial begin
        logic pop_p;
        forever begin
            @(negedge Clk);
            #2;
            pop_p = rdreq;
            @(posedge Clk);
            #1;
            if (pop_p) begin
                rdreq_cnt++;
                if (fifo_q.size() > 0) rddata = fifo_q.pop_front();
                else rddata = 8'hEE;
            end
            rdusedw = (fifo_q.size() > 4095) ? 12'hFFF : 12'(fifo_q.size());
        end
    end

    // Monitor: every cycle after a Tx_Req the DUT owes one byte on Tx_Data.
    initial begin
        logic req_prev;
        logic [7:0] e;
        forever begin
            @(posedge Clk);
            req_prev = Tx_Req;
            @(negedge Clk);
            if (req_prev) begin
                if (exp_q.size() == 0) begin
                    check("tx_data_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_data", int'(Tx_Data), int'(e));
                end
            end
            if (Seq_Err)  seq_cnt++;
            if (Abort)    abort_cnt++;
            if (Tx_Start) start_cnt++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic load_record(input logic [15:0] line, input int seed, input int nbytes);
        for (int i = 0; i < PKT; i++) begin
            if (i == 0)      rec[i] = line[7:0];
            else if (i == 1) rec[i] = line[15:8];
            else             rec[i] = 8'(i - 2 + seed);
        end
        for (int i = 0; i < nbytes; i++) fifo_q.push_back(rec[i]);
    endtask

    task automatic wait_start(input int budget, output int got);
        got = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge Clk);
            if (Tx_Start) begin
                got = 1;
                break;
            end
        end
    endtask

    task automatic send_pkt(input int nreq, input int abort_at, input logic [15:0] line,
                            input int budget, input bit chk_gap, input bit chk_seq,
                            input int exp_seq);
        int r0, a0, s0, got;
        r0 = rdreq_cnt;
        a0 = abort_cnt;
        s0 = seq_cnt;
        wait_start(budget, got);
        check("tx_start_seen", got, 1);
        if (got == 0) return;
        check("tx_byte_num", int'(Tx_Byte_Num), PKT);
        if (chk_gap) check("ifg_spacing_ok", int'((cyc - done_cyc) >= IFG), 1);
        @(negedge Clk);
        for (int i = 0; i < nreq; i++) begin
            Tx_Req = 1'b1;
            if (abort_at >= 0 && i == abort_at - 2) fifo_aclr = 1'b1;
            if (i >= PKT || (abort_at >= 0 && i >= abort_at)) exp_q.push_back(8'h00);
            else exp_q.push_back(rec[i]);
            @(negedge Clk);
        end
        Tx_Req = 1'b0;
        repeat (3) @(negedge Clk);
        Tx_Done = 1'b1;
        done_cyc = cyc;
        @(negedge Clk);
        Tx_Done = 1'b0;
        if (abort_at >= 0) begin
            fifo_aclr = 1'b0;
            fifo_q.delete();
        end
        check("rdreq_count", rdreq_cnt - r0, (abort_at >= 0) ? abort_at : ((nreq < PKT) ? nreq : PKT));
        check("abort_pulses", abort_cnt - a0, (abort_at >= 0) ? 1 : 0);
        check("line_num", int'(Line_Num), int'(line));
        if (chk_seq) check("seq_err_pulses", seq_cnt - s0, exp_seq);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        int got, st0;

        repeat (3) @(negedge Clk);
        check("rst_tx_start", int'(Tx_Start), 0);
        check("rst_byte_num", int'(Tx_Byte_Num), 0);
        check("rst_line_num", int'(Line_Num), 0);
        check("rst_seq_err", int'(Seq_Err), 0);
        check("rst_abort", int'(Abort), 0);
        check("rst_rdreq", int'(rdreq), 0);
        check("rst_tx_data", int'(Tx_Data), 0);
        Rst_n = 1'b1;
        repeat (2) @(negedge Clk);

        // Single preloaded record, line 5.
        load_record(16'd5, 0, PKT);
        send_pkt(PKT, -1, 16'd5, 200, 1'b0, 1'b0, 0);

        // One byte short: no start until the last byte arrives.
        load_record(16'd6, 3, PKT - 1);
        st0 = start_cnt;
        repeat (1000) @(negedge Clk);
        check("short_no_start", start_cnt - st0, 0);
        fifo_q.push_back(rec[PKT - 1]);
        send_pkt(PKT, -1, 16'd6, 3, 1'b1, 1'b1, 0);

        // Lines 0,1,2,4: only line 4 is a discontinuity.
        load_record(16'd0, 7, PKT);
        send_pkt(PKT, -1, 16'd0, 200, 1'b1, 1'b1, 0);
        load_record(16'd1, 11, PKT);
        send_pkt(PKT, -1, 16'd1, 200, 1'b1, 1'b1, 0);
        load_record(16'd2, 13, PKT);
        send_pkt(PKT, -1, 16'd2, 200, 1'b1, 1'b1, 0);
        load_record(16'd4, 17, PKT);
        send_pkt(PKT, -1, 16'd4, 200, 1'b1, 1'b1, 1);

        // Wrap region: 4 -> FFFE breaks sequence, FFFF and 0000 do not.
        load_record(16'hFFFE, 19, PKT);
        send_pkt(PKT, -1, 16'hFFFE, 200, 1'b1, 1'b1, 1);
        load_record(16'hFFFF, 23, PKT);
        send_pkt(PKT, -1, 16'hFFFF, 200, 1'b1, 1'b1, 0);
        load_record(16'h0000, 29, PKT);
        send_pkt(PKT, -1, 16'h0000, 200, 1'b1, 1'b1, 0);

        // FIFO clear reaches the read domain at byte 600.
        load_record(16'd7, 31, PKT);
        send_pkt(PKT, 600, 16'd7, 200, 1'b1, 1'b0, 0);

        // Over-long request burst after returning to idle.
        load_record(16'd8, 37, PKT);
        send_pkt(1290, -1, 16'd8, 200, 1'b1, 1'b1, 0);

        // Asynchronous reset in the middle of a packet.
        load_record(16'h0030, 41, PKT);
        wait_start(200, got);
        check("pre_reset_start", got, 1);
        @(negedge Clk);
        for (int i = 0; i < 300; i++) begin
            Tx_Req = 1'b1;
            exp_q.push_back(rec[i]);
            @(negedge Clk);
        end
        Tx_Req = 1'b0;
        repeat (2) @(negedge Clk);
        #3;
        Rst_n = 1'b0;
        #1;
        check("mid_rst_line_num", int'(Line_Num), 0);
        check("mid_rst_byte_num", int'(Tx_Byte_Num), 0);
        check("mid_rst_tx_start", int'(Tx_Start), 0);
        check("mid_rst_tx_data", int'(Tx_Data), 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        fifo_q.delete();
        load_record(16'h0031, 43, PKT);
        send_pkt(PKT, -1, 16'h0031, 10, 1'b0, 1'b0, 0);

        repeat (5) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
